// File: rtl/score_bcd_converter_if.sv
// score_bcd_converter_if: start/score request and BCD result bundle for the score converter
interface score_bcd_converter_if #(
  parameter int BIN_WIDTH = 26,
  parameter int DIGITS    = 6
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [DIGITS*4-1:0]   bcd;
  modport master (output start, bin, input busy, done, overflow, bcd);
  modport slave  (input start, bin, output busy, done, overflow, bcd);
endinterface

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: double-dabble binary-to-BCD sequencer with saturation; SCORE_BCD_AUTO_CONVERT_EN enables conversion on score change
module score_bcd_converter #(
  parameter int BIN_WIDTH = 26,
  parameter int DIGITS    = 6,
  parameter int CNT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  score_bcd_converter_if.slave  bus
);
  localparam logic [63:0] LIMIT = 64'(10) ** DIGITS - 64'd1;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t                 state;
  logic [BIN_WIDTH-1:0]   shreg;
  logic [DIGITS*4-1:0]    work;
  logic [DIGITS*4-1:0]    adj;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   ovf_pending;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic [DIGITS*4-1:0]    bcd;
  logic                   fire;
`ifdef SCORE_BCD_AUTO_CONVERT_EN
  logic [BIN_WIDTH-1:0]   last_bin;
  assign fire = bus.start || (bus.bin != last_bin);
  // remember the score last captured so a change can trigger the next conversion
  always_ff @(posedge clk)
    if (!reset)
      last_bin <= '0;
    else if (state == IDLE && fire)
      last_bin <= bus.bin;
`else
  assign fire = bus.start;
`endif
  // add-3 correction of every working digit that is 5 or more before the shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[i*4 +: 4] = work[i*4 +: 4] >= 4'd5 ? work[i*4 +: 4] + 4'd3 : work[i*4 +: 4];
  end
  // conversion sequencer with registered outputs; result registers only change at FINISH
  always_ff @(posedge clk)
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      work        <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      bcd         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (fire) begin
            shreg       <= bus.bin;
            work        <= '0;
            ovf_pending <= 64'(bus.bin) > LIMIT;
            cnt         <= CNT_WIDTH'(BIN_WIDTH);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        SHIFT: begin
          {work, shreg} <= {adj[DIGITS*4-2:0], shreg, 1'b0};
          cnt           <= cnt - 1'b1;
          if (cnt == CNT_WIDTH'(1))
            state <= FINISH;
        end
        FINISH: begin
          bcd      <= ovf_pending ? {DIGITS{4'h9}} : work;
          overflow <= ovf_pending;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = overflow;
  assign bus.bcd      = bcd;
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed vector bench for score_bcd_converter
module tb_score_bcd_converter;
  localparam int BW = 26;
  localparam int DG = 6;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;
  always #20 clk = ~clk;
  score_bcd_converter_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus ();
  score_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG), .CNT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  typedef struct {
    logic [BW-1:0]   b;
    logic [DG*4-1:0] e_bcd;
    logic            e_ovf;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic convert(input logic [BW-1:0] b, input logic [DG*4-1:0] e_bcd, input logic e_ovf);
    logic [DG*4-1:0] prev;
    int lat;
    logic stable;
    @(negedge clk);
    bus.bin = b;
    bus.start = 1'b1;
    prev = bus.bcd;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk($sformatf("busy_after_start_%0d", b), 64'(bus.busy), 64'd1);
    lat = 0;
    stable = 1'b1;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (!bus.done && bus.bcd !== prev) stable = 1'b0;
    end
    chk($sformatf("latency_%0d", b), 64'(lat), 64'd27);
    chk($sformatf("bcd_stable_%0d", b), 64'(stable), 64'd1);
    chk($sformatf("bcd_%0d", b), 64'(bus.bcd), 64'(e_bcd));
    chk($sformatf("ovf_%0d", b), 64'(bus.overflow), 64'(e_ovf));
    chk($sformatf("busy_at_done_%0d", b), 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 chk($sformatf("done_single_%0d", b), 64'(bus.done), 64'd0);
    chk($sformatf("busy_after_done_%0d", b), 64'(bus.busy), 64'd0);
  endtask
  initial begin
    int k;
    int n;
    logic changed;
    logic saw_done;
    vecs[0] = '{26'd123456,   24'h123456, 1'b0};
    vecs[1] = '{26'd999999,   24'h999999, 1'b0};
    vecs[2] = '{26'd1000000,  24'h999999, 1'b1};
    vecs[3] = '{26'd67108863, 24'h999999, 1'b1};
    vecs[4] = '{26'd0,        24'h000000, 1'b0};
    vecs[5] = '{26'd9,        24'h000009, 1'b0};
    vecs[6] = '{26'd10,       24'h000010, 1'b0};
    vecs[7] = '{26'd98765,    24'h098765, 1'b0};
    vecs[8] = '{26'd500000,   24'h500000, 1'b0};
    vecs[9] = '{26'd555,      24'h000555, 1'b0};
    bus.start = 1'b0;
    bus.bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_overflow", 64'(bus.overflow), 64'd0);
    chk("reset_bcd", 64'(bus.bcd), 64'd0);
    changed = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1 if (bus.busy || bus.done || bus.overflow || bus.bcd !== '0) changed = 1'b1;
    end
    chk("idle_outputs_constant", 64'(changed), 64'd0);
    for (int i = 0; i < 10; i++) convert(vecs[i].b, vecs[i].e_bcd, vecs[i].e_ovf);
    @(negedge clk);
    bus.bin = 26'd42;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 40) begin
      @(posedge clk);
      #1 k++;
      if (k == 10) begin
        bus.bin = 26'd777;
        bus.start = 1'b1;
      end else if (k == 11) begin
        bus.bin = 26'd42;
        bus.start = 1'b0;
      end
    end
    chk("ignored_start_latency", 64'(k), 64'd27);
    chk("ignored_start_bcd", 64'(bus.bcd), 64'h42);
    @(posedge clk);
    #1 chk("ignored_start_busy_after", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.bin = 26'd7;
    bus.start = 1'b1;
    k = 0;
    while (!bus.done && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chk("b2b_first_done", 64'(bus.done), 64'd1);
    k = 0;
    do begin
      @(posedge clk);
      #1 k++;
    end while (!bus.done && k < 40);
    bus.start = 1'b0;
    chk("b2b_interval", 64'(k), 64'd28);
    chk("b2b_bcd", 64'(bus.bcd), 64'h7);
    @(posedge clk);
    #1 chk("b2b_stops", 64'(bus.busy), 64'd0);
    convert(26'd555, 24'h000555, 1'b0);
    @(negedge clk);
    bus.bin = 26'd314159;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    saw_done = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1 if (bus.done) saw_done = 1'b1;
    end
    reset = 1'b0;
    bus.bin = '0;
    repeat (2) begin
      @(posedge clk);
      #1 if (bus.done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_bcd", 64'(bus.bcd), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    convert(26'd314159, 24'h314159, 1'b0);
`ifdef SCORE_BCD_AUTO_CONVERT_EN
    @(negedge clk);
    bus.bin = 26'd0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    bus.bin = 26'd10;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done) n++;
    end
    chk("auto_10_dones", 64'(n), 64'd1);
    chk("auto_10_bcd", 64'(bus.bcd), 64'h10);
    @(negedge clk);
    bus.bin = 26'd20;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done) n++;
    end
    chk("auto_20_dones", 64'(n), 64'd1);
    chk("auto_20_bcd", 64'(bus.bcd), 64'h20);
    n = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (bus.done) n++;
    end
    chk("auto_constant_no_done", 64'(n), 64'd0);
`else
    @(negedge clk);
    bus.bin = 26'd10;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.done || bus.busy) n++;
    end
    chk("no_auto_on_bin_change", 64'(n), 64'd0);
    chk("no_auto_bcd_held", 64'(bus.bcd), 64'h314159);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
